// File: rtl/tanh_pkg.sv
// Shared widths, fixed-point constants and FSM state encoding for the tanh
// activation stage.
package tanh_pkg;

  localparam int ACC_W     = 36;
  localparam int DATA_W    = 16;
  localparam int LUT_AW    = 12;
  localparam int IDX_MAX   = 511;
  localparam int FRAC_BITS = 23;

  localparam logic [LUT_AW-1:0] IDX_MAX_A = LUT_AW'(IDX_MAX);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    CALC  = 3'd3,
    OUT   = 3'd4
  } tanh_state_e;

endpackage

// File: rtl/tanh_lerp.sv
// Combinational linear interpolation between two unsigned LUT entries,
// followed by optional two's-complement negation.
module tanh_lerp
  import tanh_pkg::*;
(
  input  logic [DATA_W-1:0]    lo_i,
  input  logic [DATA_W-1:0]    hi_i,
  input  logic [FRAC_BITS-1:0] frac_i,
  input  logic                 sign_i,
  output logic [DATA_W-1:0]    y_o
);

  logic [FRAC_BITS:0]               inv_frac;
  logic [DATA_W+FRAC_BITS+1:0]      sum;

  assign inv_frac = {1'b1, {FRAC_BITS{1'b0}}} - {1'b0, frac_i};

  assign sum = (DATA_W+FRAC_BITS+2)'(lo_i) * (DATA_W+FRAC_BITS+2)'(inv_frac)
             + (DATA_W+FRAC_BITS+2)'(hi_i) * (DATA_W+FRAC_BITS+2)'(frac_i);

  // Truncating shift; the interpolated magnitude never exceeds the larger entry.
  assign y_o = DATA_W'(sign_i ? -(sum >> FRAC_BITS) : (sum >> FRAC_BITS));

endmodule

// File: rtl/tanh_interp_stage.sv
// Pipelined tanh stage: accept one accumulator sum, read two adjacent LUT
// entries, interpolate, and hold the signed result until downstream accepts.
module tanh_interp_stage
  import tanh_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              acc_valid,
  output logic              acc_ready,
  input  logic [ACC_W-1:0]  acc_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [LUT_AW-1:0] tanh__tanhmem__read_address,
  input  logic [DATA_W-1:0] tanhmem__tanh__read_data
);

  tanh_state_e          state_q, state_d;
  logic                 sign_q, sign_d;
  logic                 clamp_q, clamp_d;
  logic [LUT_AW-1:0]    idx_q, idx_d;
  logic [FRAC_BITS-1:0] frac_q, frac_d;
  logic [LUT_AW-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    lo_q, lo_d;
  logic [DATA_W-1:0]    out_q, out_d;

  logic [ACC_W-1:0]     abs_full;
  logic [ACC_W-2:0]     mag;
  logic [LUT_AW-1:0]    idx_raw;
  logic                 clamp_raw;
  logic [DATA_W-1:0]    lerp_y;

  // Magnitude saturates so that -2^35 lands on 2^35-1 instead of wrapping.
  assign abs_full  = acc_data[ACC_W-1] ? (~acc_data + 1'b1) : acc_data;
  assign mag       = abs_full[ACC_W-1] ? '1 : abs_full[ACC_W-2:0];
  assign idx_raw   = mag[ACC_W-2:FRAC_BITS];
  assign clamp_raw = (idx_raw >= IDX_MAX_A);

  tanh_lerp u_lerp (
    .lo_i   (lo_q),
    .hi_i   (tanhmem__tanh__read_data),
    .frac_i (frac_q),
    .sign_i (sign_q),
    .y_o    (lerp_y)
  );

  always_comb begin
    // NOTE: every next-state signal defaults to its register so no path infers a latch.
    state_d = state_q;
    sign_d  = sign_q;
    clamp_d = clamp_q;
    idx_d   = idx_q;
    frac_d  = frac_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (acc_valid) begin
          sign_d  = acc_data[ACC_W-1];
          clamp_d = clamp_raw;
          idx_d   = clamp_raw ? IDX_MAX_A : idx_raw;
          frac_d  = clamp_raw ? '0 : mag[FRAC_BITS-1:0];
          addr_d  = clamp_raw ? IDX_MAX_A : idx_raw;
          state_d = RD_LO;
        end
      end
      RD_LO: begin
        addr_d  = clamp_q ? IDX_MAX_A : idx_q + LUT_AW'(1);
        state_d = RD_HI;
      end
      RD_HI: begin
        lo_d    = tanhmem__tanh__read_data;
        state_d = CALC;
      end
      CALC: begin
        out_d   = lerp_y;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      clamp_q <= 1'b0;
      idx_q   <= '0;
      frac_q  <= '0;
      addr_q  <= '0;
      lo_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      clamp_q <= clamp_d;
      idx_q   <= idx_d;
      frac_q  <= frac_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      out_q   <= out_d;
    end
  end

  assign acc_ready                   = (state_q == IDLE);
  assign busy                        = (state_q != IDLE);
  assign out_valid                   = (state_q == OUT);
  assign out_data                    = out_q;
  assign tanh__tanhmem__read_address = addr_q;

endmodule

// File: tb/tb_tanh_interp_stage.sv
// Directed bench for tanh_interp_stage against a linear LUT L[k] = 64*k.
module tb_tanh_interp_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        acc_valid;
  logic        acc_ready;
  logic [35:0] acc_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;
  logic [11:0] rd_addr;
  logic [15:0] rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // One-cycle-latency LUT model.
  always @(posedge clk) rd_data <= 16'(rd_addr * 64);

  tanh_interp_stage dut (
    .clk                         (clk),
    .reset                       (reset),
    .acc_valid                   (acc_valid),
    .acc_ready                   (acc_ready),
    .acc_data                    (acc_data),
    .out_valid                   (out_valid),
    .out_ready                   (out_ready),
    .out_data                    (out_data),
    .busy                        (busy),
    .tanh__tanhmem__read_address (rd_addr),
    .tanhmem__tanh__read_data    (rd_data)
  );

  typedef struct {
    logic [35:0] acc;
    logic [15:0] exp_y;
    logic [11:0] lo_a;
    logic [11:0] hi_a;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction starting in IDLE; hold > 0 stalls OUT for that many cycles.
  task automatic run_txn(input string tag, input logic [35:0] acc, input logic [15:0] exp_y,
                         input logic [11:0] lo_a, input logic [11:0] hi_a, input int hold);
    logic [11:0] held_addr;
    check({tag, " ready_idle"}, 64'(acc_ready), 64'd1);
    acc_valid = 1'b1;
    acc_data  = acc;
    out_ready = (hold == 0);
    tick();
    acc_valid = 1'b0;
    acc_data  = 36'h5_A5A5_A5A5;
    check({tag, " addr_lo"}, 64'(rd_addr), 64'(lo_a));
    check({tag, " busy_rdlo"}, 64'({busy, acc_ready}), 64'b10);
    tick();
    check({tag, " addr_hi"}, 64'(rd_addr), 64'(hi_a));
    tick();
    check({tag, " no_valid_calc"}, 64'(out_valid), 64'd0);
    tick();
    check({tag, " valid_e3"}, 64'(out_valid), 64'd1);
    check({tag, " data"}, 64'(out_data), 64'(exp_y));
    held_addr = rd_addr;
    for (int c = 0; c < hold; c++) begin
      tick();
      check({tag, " stall_hold"}, 64'({out_valid, acc_ready, busy, out_data, rd_addr}),
            64'({1'b1, 1'b0, 1'b1, exp_y, held_addr}));
    end
    out_ready = 1'b1;
    tick();
    check({tag, " back_idle"}, 64'({out_valid, busy, acc_ready}), 64'b001);
  endtask

  initial begin
    int accepts[$];
    int watchdog;

    vecs[0] = '{36'h0_01C0_0000, 16'h00E0,   3,   4};
    vecs[1] = '{36'hF_FE40_0000, 16'hFF20,   3,   4};
    vecs[2] = '{36'h7_FFFF_FFFF, 16'h7FC0, 511, 511};
    vecs[3] = '{36'h8_0000_0000, 16'h8040, 511, 511};
    vecs[4] = '{36'h0_0000_0000, 16'h0000,   0,   1};
    vecs[5] = '{36'h0_0520_0000, 16'h0290,  10,  11};
    vecs[6] = '{36'h0_FF40_0000, 16'h7FA0, 510, 511};
    vecs[7] = '{36'h0_FF80_0123, 16'h7FC0, 511, 511};
    vecs[8] = '{36'h0_007F_FFFF, 16'h003F,   0,   1};

    reset     = 1'b1;
    acc_valid = 1'b0;
    acc_data  = '0;
    out_ready = 1'b1;
    #1;
    check("reset_state", 64'({out_valid, busy, acc_ready, out_data, rd_addr}), 64'({3'b001, 16'h0, 12'h0}));
    tick();
    tick();
    reset = 1'b0;
    tick();

    foreach (vecs[k])
      run_txn($sformatf("vec%0d", k), vecs[k].acc, vecs[k].exp_y, vecs[k].lo_a, vecs[k].hi_a, 0);

    run_txn("stall", 36'h0_0520_0000, 16'h0290, 10, 11, 10);

    // Reset asserted during CALC drops everything immediately.
    acc_valid = 1'b1;
    acc_data  = 36'h0_01C0_0000;
    tick();
    acc_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("reset_in_calc", 64'({out_valid, busy, acc_ready, rd_addr}), 64'({3'b001, 12'h0}));
    tick();
    check("reset_held", 64'({out_valid, busy, acc_ready, out_data}), 64'({3'b001, 16'h0}));
    reset = 1'b0;
    tick();
    run_txn("after_reset", 36'h0_01C0_0000, 16'h00E0, 3, 4, 0);

    // Back-to-back requests with downstream always ready.
    acc_valid = 1'b1;
    acc_data  = '0;
    out_ready = 1'b1;
    watchdog  = 0;
    while (accepts.size() < 4 && watchdog < 40) begin
      if (acc_ready && acc_valid) accepts.push_back(watchdog);
      tick();
      watchdog++;
    end
    acc_valid = 1'b0;
    check("b2b_accept_count", 64'(accepts.size()), 64'd4);
    for (int k = 1; k < accepts.size(); k++)
      check($sformatf("b2b_spacing%0d", k), 64'(accepts[k] - accepts[k-1]), 64'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
